gbf_fill_scheduler: RTL and testbench

GBF_FILL_SCHEDULER -- requirements
Module: gbf_fill_scheduler

---
 rtl/gbf_fill_pkg.sv | 35 +++
 rtl/gbf_fill_rr_arb.sv | 45 ++++
 rtl/gbf_fill_scheduler.sv | 203 ++++++++++++++++++++
 tb/tb_gbf_fill_scheduler.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gbf_fill_pkg.sv
// Shared FSM state encoding and requester indices for the GBF fill scheduler.
package gbf_fill_pkg;

  localparam int NUM_REQ   = 4;
  localparam int REQ_IDX_W = 2;

  // Requester order doubles as the round-robin search order.
  localparam logic [REQ_IDX_W-1:0] REQ_ACTV1 = 2'd0;
  localparam logic [REQ_IDX_W-1:0] REQ_WGT1  = 2'd1;
  localparam logic [REQ_IDX_W-1:0] REQ_ACTV2 = 2'd2;
  localparam logic [REQ_IDX_W-1:0] REQ_WGT2  = 2'd3;

  localparam logic [NUM_REQ-1:0] ACTV_MASK = 4'b0101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    XFER = 2'd2,
    DONE = 2'd3
  } fill_state_t;

  function automatic logic [REQ_IDX_W-1:0] onehot_idx(input logic [NUM_REQ-1:0] oh);
    logic [REQ_IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (oh[i]) idx = idx | REQ_IDX_W'(i);
    end
    return idx;
  endfunction

  function automatic logic is_actv(input logic [REQ_IDX_W-1:0] idx);
    return ~idx[0];
  endfunction

endpackage

// File: rtl/gbf_fill_rr_arb.sv
// Four-way round-robin arbiter, one-hot grant, pointer advances past the winner on accept.
// Optional GBF_FILL_ACTV_PRIO_EN: eligible activation requests beat weight requests.
module gbf_fill_rr_arb
  import gbf_fill_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  input  logic               accept,
  output logic [NUM_REQ-1:0] grant
);

  logic [REQ_IDX_W-1:0] ptr_q, ptr_d;
  logic [NUM_REQ-1:0]   cand;
  logic [REQ_IDX_W-1:0] idx;
  logic                 found;

  always_comb begin
    cand = req;
`ifdef GBF_FILL_ACTV_PRIO_EN
    if (|(req & ACTV_MASK)) cand = req & ACTV_MASK;
`endif
    grant = '0;
    found = 1'b0;
    idx   = '0;
    // ptr_q holds the first index to search, i.e. one past the last winner.
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = ptr_q + REQ_IDX_W'(i);
      if (!found && cand[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
    ptr_d = ptr_q;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (accept && grant[i]) ptr_d = REQ_IDX_W'(i + 1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

endmodule

// File: rtl/gbf_fill_scheduler.sv
// Fills four GBF buffers from an off-chip burst source: arbitrate, request, stream, pulse ready.
// Optional GBF_FILL_ACTV_PRIO_EN gives activation buffers priority over weight buffers.
module gbf_fill_scheduler
  import gbf_fill_pkg::*;
#(
  parameter int GBF_DATA_BITWIDTH = 512,
  parameter int GBF_ADDR_BITWIDTH = 5,
  parameter int GBF_DEPTH         = 32,
  parameter int SRC_ADDR_BITWIDTH = 32
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [SRC_ADDR_BITWIDTH-1:0] actv_base_addr,
  input  logic [SRC_ADDR_BITWIDTH-1:0] wgt_base_addr,
  input  logic [GBF_ADDR_BITWIDTH:0]   fill_len,
  input  logic                         actv_gbf1_need_data,
  input  logic                         actv_gbf2_need_data,
  input  logic                         wgt_gbf1_need_data,
  input  logic                         wgt_gbf2_need_data,
  output logic                         src_req,
  output logic [SRC_ADDR_BITWIDTH-1:0] src_addr,
  input  logic                         src_ack,
  input  logic                         src_valid,
  input  logic [GBF_DATA_BITWIDTH-1:0] src_data,
  output logic                         src_ready,
  output logic                         actv_en1a,
  output logic                         actv_we1a,
  output logic                         actv_en2a,
  output logic                         actv_we2a,
  output logic                         wgt_en1a,
  output logic                         wgt_we1a,
  output logic                         wgt_en2a,
  output logic                         wgt_we2a,
  output logic [GBF_ADDR_BITWIDTH-1:0] gbf_addr,
  output logic [GBF_DATA_BITWIDTH-1:0] gbf_w_data,
  output logic                         gbf_actv_buf1_ready,
  output logic                         gbf_actv_buf2_ready,
  output logic                         gbf_wgt_buf1_ready,
  output logic                         gbf_wgt_buf2_ready,
  output logic                         gbf_actv_data_avail,
  output logic                         gbf_wgt_data_avail,
  output logic                         busy
);

  localparam int LW = GBF_ADDR_BITWIDTH + 1;

  fill_state_t                  state_q, state_d;
  logic [REQ_IDX_W-1:0]         gnt_idx_q, gnt_idx_d;
  logic [LW-1:0]                len_q, len_d;
  logic [LW-1:0]                cnt_q, cnt_d;
  logic [SRC_ADDR_BITWIDTH-1:0] actv_ptr_q, actv_ptr_d;
  logic [SRC_ADDR_BITWIDTH-1:0] wgt_ptr_q, wgt_ptr_d;
  logic [NUM_REQ-1:0]           served_q, served_d;
  logic [1:0]                   avail_q, avail_d;
  logic                         src_req_q, src_req_d;
  logic [SRC_ADDR_BITWIDTH-1:0] src_addr_q, src_addr_d;
  logic                         src_ready_q, src_ready_d;
  logic [NUM_REQ-1:0]           wr_sel_q, wr_sel_d;
  logic [GBF_ADDR_BITWIDTH-1:0] gbf_addr_q, gbf_addr_d;
  logic [GBF_DATA_BITWIDTH-1:0] gbf_w_data_q, gbf_w_data_d;
  logic [NUM_REQ-1:0]           rdy_q, rdy_d;

  logic [NUM_REQ-1:0]   need;
  logic [NUM_REQ-1:0]   eligible;
  logic [NUM_REQ-1:0]   grant_oh;
  logic                 arb_accept;
  logic [LW-1:0]        eff_len;
  logic [LW-1:0]        cnt_nxt;
  logic [REQ_IDX_W-1:0] grant_idx;

  assign need       = {wgt_gbf2_need_data, actv_gbf2_need_data, wgt_gbf1_need_data, actv_gbf1_need_data};
  assign eligible   = need & ~served_q;
  assign arb_accept = (state_q == IDLE) && !start && (|eligible);
  assign eff_len    = (fill_len == '0) ? LW'(GBF_DEPTH) : fill_len;
  assign cnt_nxt    = cnt_q + LW'(1);
  assign grant_idx  = onehot_idx(grant_oh);

  gbf_fill_rr_arb u_arb (
    .clk    (clk),
    .reset  (reset),
    .req    (eligible),
    .accept (arb_accept),
    .grant  (grant_oh)
  );

  always_comb begin
    state_d      = state_q;
    gnt_idx_d    = gnt_idx_q;
    len_d        = len_q;
    cnt_d        = cnt_q;
    actv_ptr_d   = actv_ptr_q;
    wgt_ptr_d    = wgt_ptr_q;
    avail_d      = avail_q;
    src_req_d    = src_req_q;
    src_addr_d   = src_addr_q;
    src_ready_d  = src_ready_q;
    gbf_addr_d   = gbf_addr_q;
    gbf_w_data_d = gbf_w_data_q;
    wr_sel_d     = '0;
    rdy_d        = '0;
    // A served flag survives only while its need line stays high.
    served_d     = served_q & need;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          actv_ptr_d = actv_base_addr;
          wgt_ptr_d  = wgt_base_addr;
          avail_d    = '0;
        end else if (|eligible) begin
          gnt_idx_d  = grant_idx;
          len_d      = eff_len;
          cnt_d      = '0;
          src_req_d  = 1'b1;
          src_addr_d = is_actv(grant_idx) ? actv_ptr_q : wgt_ptr_q;
          state_d    = REQ;
        end
      end
      REQ: begin
        if (src_ack) begin
          src_req_d   = 1'b0;
          src_ready_d = 1'b1;
          state_d     = XFER;
        end
      end
      XFER: begin
        if (src_valid && src_ready_q) begin
          wr_sel_d[gnt_idx_q] = 1'b1;
          gbf_addr_d          = cnt_q[GBF_ADDR_BITWIDTH-1:0];
          gbf_w_data_d        = src_data;
          cnt_d               = cnt_nxt;
          if (cnt_nxt == len_q) begin
            src_ready_d = 1'b0;
            state_d     = DONE;
          end
        end
      end
      DONE: begin
        if (is_actv(gnt_idx_q)) begin
          actv_ptr_d = actv_ptr_q + SRC_ADDR_BITWIDTH'(len_q);
          avail_d[0] = 1'b1;
        end else begin
          wgt_ptr_d  = wgt_ptr_q + SRC_ADDR_BITWIDTH'(len_q);
          avail_d[1] = 1'b1;
        end
        served_d[gnt_idx_q] = 1'b1;
        rdy_d[gnt_idx_q]    = 1'b1;
        state_d             = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      gnt_idx_q    <= '0;
      len_q        <= '0;
      cnt_q        <= '0;
      actv_ptr_q   <= '0;
      wgt_ptr_q    <= '0;
      served_q     <= '0;
      avail_q      <= '0;
      src_req_q    <= 1'b0;
      src_addr_q   <= '0;
      src_ready_q  <= 1'b0;
      wr_sel_q     <= '0;
      gbf_addr_q   <= '0;
      gbf_w_data_q <= '0;
      rdy_q        <= '0;
    end else begin
      state_q      <= state_d;
      gnt_idx_q    <= gnt_idx_d;
      len_q        <= len_d;
      cnt_q        <= cnt_d;
      actv_ptr_q   <= actv_ptr_d;
      wgt_ptr_q    <= wgt_ptr_d;
      served_q     <= served_d;
      avail_q      <= avail_d;
      src_req_q    <= src_req_d;
      src_addr_q   <= src_addr_d;
      src_ready_q  <= src_ready_d;
      wr_sel_q     <= wr_sel_d;
      gbf_addr_q   <= gbf_addr_d;
      gbf_w_data_q <= gbf_w_data_d;
      rdy_q        <= rdy_d;
    end
  end

  assign src_req    = src_req_q;
  assign src_addr   = src_addr_q;
  assign src_ready  = src_ready_q;
  assign gbf_addr   = gbf_addr_q;
  assign gbf_w_data = gbf_w_data_q;
  assign busy       = (state_q != IDLE);

  assign {wgt_en2a, actv_en2a, wgt_en1a, actv_en1a} = wr_sel_q;
  assign {wgt_we2a, actv_we2a, wgt_we1a, actv_we1a} = wr_sel_q;
  assign {gbf_wgt_buf2_ready, gbf_actv_buf2_ready, gbf_wgt_buf1_ready, gbf_actv_buf1_ready} = rdy_q;
  assign {gbf_wgt_data_avail, gbf_actv_data_avail} = avail_q;

endmodule

// File: tb/tb_gbf_fill_scheduler.sv
// Randomized bench for gbf_fill_scheduler against a transaction-level fill model.
module tb_gbf_fill_scheduler;

  localparam int DW    = 512;
  localparam int AW    = 5;
  localparam int DEPTH = 32;
  localparam int SW    = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [SW-1:0] actv_base_addr = '0;
  logic [SW-1:0] wgt_base_addr = '0;
  logic [AW:0]   fill_len = 6'd4;
  logic [3:0]    need = '0;
  logic          src_ack = 1'b0;
  logic          src_valid = 1'b0;
  logic [DW-1:0] src_data = '0;

  logic          src_req, src_ready, busy;
  logic [SW-1:0] src_addr;
  logic          actv_en1a, actv_we1a, actv_en2a, actv_we2a;
  logic          wgt_en1a, wgt_we1a, wgt_en2a, wgt_we2a;
  logic [AW-1:0] gbf_addr;
  logic [DW-1:0] gbf_w_data;
  logic          gbf_actv_buf1_ready, gbf_actv_buf2_ready, gbf_wgt_buf1_ready, gbf_wgt_buf2_ready;
  logic          gbf_actv_data_avail, gbf_wgt_data_avail;

  gbf_fill_scheduler dut (
    .clk                 (clk),
    .reset               (reset),
    .start               (start),
    .actv_base_addr      (actv_base_addr),
    .wgt_base_addr       (wgt_base_addr),
    .fill_len            (fill_len),
    .actv_gbf1_need_data (need[0]),
    .wgt_gbf1_need_data  (need[1]),
    .actv_gbf2_need_data (need[2]),
    .wgt_gbf2_need_data  (need[3]),
    .src_req             (src_req),
    .src_addr            (src_addr),
    .src_ack             (src_ack),
    .src_valid           (src_valid),
    .src_data            (src_data),
    .src_ready           (src_ready),
    .actv_en1a           (actv_en1a),
    .actv_we1a           (actv_we1a),
    .actv_en2a           (actv_en2a),
    .actv_we2a           (actv_we2a),
    .wgt_en1a            (wgt_en1a),
    .wgt_we1a            (wgt_we1a),
    .wgt_en2a            (wgt_en2a),
    .wgt_we2a            (wgt_we2a),
    .gbf_addr            (gbf_addr),
    .gbf_w_data          (gbf_w_data),
    .gbf_actv_buf1_ready (gbf_actv_buf1_ready),
    .gbf_actv_buf2_ready (gbf_actv_buf2_ready),
    .gbf_wgt_buf1_ready  (gbf_wgt_buf1_ready),
    .gbf_wgt_buf2_ready  (gbf_wgt_buf2_ready),
    .gbf_actv_data_avail (gbf_actv_data_avail),
    .gbf_wgt_data_avail  (gbf_wgt_data_avail),
    .busy                (busy)
  );

  always #5 clk = ~clk;

  logic [3:0] en_vec, we_vec, rdy_vec;
  logic [1:0] avail_vec;
  logic       out_any;
  assign en_vec    = {wgt_en2a, actv_en2a, wgt_en1a, actv_en1a};
  assign we_vec    = {wgt_we2a, actv_we2a, wgt_we1a, actv_we1a};
  assign rdy_vec   = {gbf_wgt_buf2_ready, gbf_actv_buf2_ready, gbf_wgt_buf1_ready, gbf_actv_buf1_ready};
  assign avail_vec = {gbf_wgt_data_avail, gbf_actv_data_avail};
  assign out_any   = src_req | (|src_addr) | src_ready | (|en_vec) | (|we_vec) | (|gbf_addr) |
                     (|gbf_w_data) | (|rdy_vec) | (|avail_vec) | busy;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Transaction-level model: stream pointers, served flags, last winner, avail flags.
  logic [SW-1:0] m_ptr [2];
  bit   [3:0]    m_served;
  int            m_last;
  bit   [1:0]    m_avail;

  function automatic void model_reset();
    m_ptr[0] = '0;
    m_ptr[1] = '0;
    m_served = '0;
    m_last   = 3;
    m_avail  = '0;
  endfunction

  function automatic int pick(input bit [3:0] elig);
    bit [3:0] c;
    c = elig;
`ifdef GBF_FILL_ACTV_PRIO_EN
    if ((elig & 4'b0101) != 0) c = elig & 4'b0101;
`endif
    for (int i = 1; i <= 4; i++) begin
      int idx;
      idx = (m_last + i) % 4;
      if (c[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic logic [DW-1:0] rand_data();
    logic [DW-1:0] d;
    for (int i = 0; i < DW / 32; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    src_valid = 1'b0;
    src_ack = 1'b0;
    start = 1'b0;
    tick();
    chk("reset_outs", out_any, 1'b0);
    reset = 1'b0;
    model_reset();
    tick();
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    m_ptr[0] = actv_base_addr;
    m_ptr[1] = wgt_base_addr;
    m_avail  = '0;
    chk("start_avail_clr", avail_vec, m_avail);
  endtask

  task automatic set_need(input logic [3:0] v);
    need = v;
    m_served &= v;
    tick();
    if (pick(need & ~m_served) < 0) begin
      tick();
      chk("no_req", src_req, 1'b0);
      chk("idle_busy", busy, 1'b0);
    end
  endtask

  // vmode: 0 random valid, 1 toggling valid, 2 always valid.
  task automatic do_fill(input int g, input logic [SW-1:0] addr, input int len, input int vmode,
                         input int abort_at, input bit start_mid, input bit drop_need);
    int            wait_n, d, k, cyc;
    bit            v;
    logic [DW-1:0] dat;
    logic [3:0]    exp_sel;
    exp_sel = 4'b0001 << g;
    wait_n = 0;
    while (!src_req && wait_n < 8) begin
      tick();
      wait_n++;
    end
    chk("req_seen", src_req, 1'b1);
    if (!src_req) return;
    chk("src_addr", src_addr, addr);
    chk("busy_req", busy, 1'b1);
    d = $urandom_range(0, 3);
    repeat (d) begin
      tick();
      chk("req_hold", src_req, 1'b1);
    end
    src_ack = 1'b1;
    tick();
    src_ack = 1'b0;
    chk("req_drop", src_req, 1'b0);
    k = 0;
    cyc = 0;
    while (k < len && cyc < 400) begin
      case (vmode)
        1:       v = (cyc % 2 == 0);
        2:       v = 1'b1;
        default: v = ($urandom_range(0, 3) != 0);
      endcase
      if (start_mid && cyc == 1) begin
        actv_base_addr = $urandom;
        wgt_base_addr  = $urandom;
        start = 1'b1;
      end
      if (drop_need && cyc == 2) need[g] = 1'b0;
      chk("src_ready_on", src_ready, 1'b1);
      src_valid = v;
      dat = rand_data();
      src_data = dat;
      tick();
      start = 1'b0;
      if (v) begin
        chk("we_sel", we_vec, exp_sel);
        chk("en_sel", en_vec, exp_sel);
        chk("wr_addr", gbf_addr, k);
        chk("wr_data", gbf_w_data, dat);
        k++;
      end else begin
        chk("we_idle", we_vec, 4'b0000);
      end
      chk("rdy_early", rdy_vec, 4'b0000);
      if (abort_at >= 0 && k == abort_at) begin
        src_valid = 1'b0;
        #2 reset = 1'b1;
        #1 chk("abort_outs", out_any, 1'b0);
        tick();
        chk("abort_no_rdy", rdy_vec, 4'b0000);
        reset = 1'b0;
        model_reset();
        return;
      end
      cyc++;
    end
    if (k < len) chk("beats_timeout", k, len);
    // Final write cycle: source is now throttled; offer a stray beat that must be dropped.
    chk("src_ready_off", src_ready, 1'b0);
    src_valid = 1'b1;
    src_data  = rand_data();
    tick();
    src_valid = 1'b0;
    m_ptr[g % 2] = m_ptr[g % 2] + SW'(len);
    m_served[g]  = 1'b1;
    m_served    &= need;
    m_last       = g;
    m_avail[g % 2] = 1'b1;
    chk("stray_ignored", we_vec, 4'b0000);
    chk("rdy_pulse", rdy_vec, exp_sel);
    chk("busy_done", busy, 1'b0);
    chk("avail", avail_vec, m_avail);
    tick();
    chk("rdy_single", rdy_vec, 4'b0000);
  endtask

  task automatic run_pending(input int vmode, input int abort_at, input bit start_mid, input bit drop_need);
    int g, len;
    g = pick(need & ~m_served);
    if (g < 0) begin
      chk("pending_expected", src_req, 1'b1);
      return;
    end
    len = (fill_len == 0) ? DEPTH : int'(fill_len);
    do_fill(g, m_ptr[g % 2], len, vmode, abort_at, start_mid, drop_need);
  endtask

  initial begin
    model_reset();
    tick();
    chk("rst_outs", out_any, 1'b0);
    reset = 1'b0;
    tick();
    chk("post_rst_outs", out_any, 1'b0);

    // Single activation fill, back-to-back beats.
    actv_base_addr = 32'h100;
    wgt_base_addr  = 32'h2000;
    do_start();
    fill_len = 6'd4;
    set_need(4'b0001);
    run_pending(2, -1, 1'b0, 1'b0);
    set_need(4'b0000);

    // All four requesting from a fresh reset: full round-robin sweep.
    do_reset();
    do_start();
    fill_len = 6'd2;
    set_need(4'b1111);
    repeat (4) run_pending(0, -1, 1'b0, 1'b0);
    tick();
    tick();
    chk("no_refill", src_req, 1'b0);

    // Need held high after service must not refill; a new requester goes next.
    set_need(4'b0010);
    set_need(4'b0110);
    run_pending(0, -1, 1'b0, 1'b0);
    set_need(4'b0010);
    set_need(4'b0000);
    set_need(4'b0010);
    run_pending(0, -1, 1'b0, 1'b0);
    set_need(4'b0000);

    // Full-depth fill with toggling valid and an ignored mid-fill start.
    fill_len = 6'd0;
    set_need(4'b0100);
    run_pending(1, -1, 1'b1, 1'b0);
    set_need(4'b0000);

    // Reset in the middle of an 8-beat fill, then refill from base 0.
    fill_len = 6'd8;
    set_need(4'b1000);
    run_pending(2, 3, 1'b0, 1'b0);
    run_pending(0, -1, 1'b0, 1'b0);
    set_need(4'b0000);

    // Randomized traffic.
    repeat (30) begin
      if (pick(need & ~m_served) >= 0) begin
        run_pending($urandom_range(0, 2), -1, ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) == 0));
      end else begin
        if ($urandom_range(0, 3) == 0) begin
          actv_base_addr = $urandom;
          wgt_base_addr  = $urandom;
          do_start();
        end
        fill_len = 6'($urandom_range(0, DEPTH));
        set_need(4'($urandom_range(0, 15)));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule
